// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with next-PC selection.
// Picks exception, jump-register, jump, branch or sequential targets.
// Holds the PC across stalls and instruction-memory waits.
// Buffers any redirect that arrives while fetch cannot advance, so none is lost.
module pc_sequencer #(
    parameter int                        DATA_BUS_WIDTH = 32,
    parameter logic [DATA_BUS_WIDTH-1:0] RESET_VECTOR   = '0,
    parameter logic [DATA_BUS_WIDTH-1:0] EXC_VECTOR     = 32'h8000_0180
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_BUS_WIDTH-1:0] id_pc_plus4,
    input  logic [DATA_BUS_WIDTH-1:0] branch_offset_sh,
    input  logic [27:0]               jump_field_sh,
    input  logic [DATA_BUS_WIDTH-1:0] jr_target,
    input  logic                      branch_taken,
    input  logic                      jump,
    input  logic                      jump_reg,
    input  logic                      exc_req,
    input  logic                      stall,
    input  logic                      imem_ready,
    output logic [DATA_BUS_WIDTH-1:0] pc,
    output logic [DATA_BUS_WIDTH-1:0] pc_plus4,
    output logic                      fetch_valid,
    output logic                      redirect_pending,
    output logic                      addr_misaligned
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t                      state_q, state_d;
    logic [DATA_BUS_WIDTH-1:0]   pc_d;
    logic [DATA_BUS_WIDTH-1:0]   pending_target, pending_target_d;
    logic                        pending_is_exc, pending_is_exc_d;
    logic                        valid_q;

    logic                        advance;
    logic                        redirect;
    logic                        keep_pending;
    logic [DATA_BUS_WIDTH-1:0]   sel_target;
    logic [DATA_BUS_WIDTH-1:0]   br_target;
    logic [DATA_BUS_WIDTH-1:0]   j_target;
    logic [DATA_BUS_WIDTH-1:0]   jr_aligned;
    logic signed [DATA_BUS_WIDTH-1:0] branch_offset_s;
    logic signed [DATA_BUS_WIDTH-1:0] id_pc_plus4_s;

    assign advance  = ~stall & imem_ready;
    assign redirect = exc_req | jump_reg | jump | branch_taken;

    // Branch arithmetic is signed offset addition, wrapping modulo 2^W.
    assign branch_offset_s = branch_offset_sh;
    assign id_pc_plus4_s   = id_pc_plus4;
    assign br_target       = $unsigned(id_pc_plus4_s + branch_offset_s);
    assign j_target        = {id_pc_plus4[DATA_BUS_WIDTH-1:28], jump_field_sh};
    assign jr_aligned      = {jr_target[DATA_BUS_WIDTH-1:2], 2'b00};

    assign pc_plus4         = pc + DATA_BUS_WIDTH'(4);
    assign redirect_pending = (state_q == HOLD);
    assign fetch_valid      = valid_q & ~redirect_pending;

    // A buffered exception survives any later non-exception redirect.
    assign keep_pending = pending_is_exc & ~exc_req;

    // Target priority mux: exception first, sequential last.
    always_comb begin
        sel_target = pc_plus4;
        if (exc_req)           sel_target = EXC_VECTOR;
        else if (jump_reg)     sel_target = jr_aligned;
        else if (jump)         sel_target = j_target;
        else if (branch_taken) sel_target = br_target;
    end

    // Next-state logic for the RUN/HOLD redirect buffer and the PC.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc;
        pending_target_d = pending_target;
        pending_is_exc_d = pending_is_exc;
        unique case (state_q)
            RUN: begin
                if (advance) begin
                    pc_d = sel_target;
                end else if (redirect) begin
                    pending_target_d = sel_target;
                    pending_is_exc_d = exc_req;
                    state_d          = HOLD;
                end
            end
            HOLD: begin
                if (redirect && !keep_pending) begin
                    pending_target_d = sel_target;
                    pending_is_exc_d = exc_req;
                end
                if (advance) begin
                    pc_d    = (redirect && !keep_pending) ? sel_target : pending_target;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State, PC and flag registers; reset discards any buffered redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            pc              <= RESET_VECTOR;
            pending_target  <= '0;
            pending_is_exc  <= 1'b0;
            valid_q         <= 1'b0;
            addr_misaligned <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc              <= pc_d;
            pending_target  <= pending_target_d;
            pending_is_exc  <= pending_is_exc_d;
            valid_q         <= 1'b1;
            addr_misaligned <= jump_reg & ~exc_req & (jr_target[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: each step queues its expected
// outputs, then pops and compares them just after the clock edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_pc_plus4;
    logic [31:0] branch_offset_sh;
    logic [27:0] jump_field_sh;
    logic [31:0] jr_target;
    logic        branch_taken, jump, jump_reg, exc_req, stall, imem_ready;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, redirect_pending, addr_misaligned;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        fv;
        logic        rp;
        logic        am;
    } exp_t;

    exp_t sb_q[$];

    pc_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_pc_plus4      (id_pc_plus4),
        .branch_offset_sh (branch_offset_sh),
        .jump_field_sh    (jump_field_sh),
        .jr_target        (jr_target),
        .branch_taken     (branch_taken),
        .jump             (jump),
        .jump_reg         (jump_reg),
        .exc_req          (exc_req),
        .stall            (stall),
        .imem_ready       (imem_ready),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending),
        .addr_misaligned  (addr_misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare all outputs against one expectation record.
    task automatic compare_rec(input exp_t e);
        check_eq({e.tag, ".pc"}, pc, e.pc);
        check_eq({e.tag, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
        check_eq({e.tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, e.fv});
        check_eq({e.tag, ".redirect_pending"}, {31'b0, redirect_pending}, {31'b0, e.rp});
        check_eq({e.tag, ".addr_misaligned"}, {31'b0, addr_misaligned}, {31'b0, e.am});
    endtask

    // Queue the expected post-edge outputs, clock once, drop pulses, compare.
    task automatic tick(input string tag, input logic [31:0] e_pc,
                        input logic e_fv, input logic e_rp, input logic e_am);
        exp_t e;
        e.tag = tag; e.pc = e_pc; e.fv = e_fv; e.rp = e_rp; e.am = e_am;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jump_reg     = 1'b0;
        exc_req      = 1'b0;
        if (sb_q.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            compare_rec(e);
        end
    endtask

    // Compare outputs immediately, without a clock edge.
    task automatic now(input string tag, input logic [31:0] e_pc,
                       input logic e_fv, input logic e_rp, input logic e_am);
        exp_t e;
        e.tag = tag; e.pc = e_pc; e.fv = e_fv; e.rp = e_rp; e.am = e_am;
        sb_q.push_back(e);
        e = sb_q.pop_front();
        compare_rec(e);
    endtask

    initial begin
        rst_n = 1'b0;
        id_pc_plus4 = '0; branch_offset_sh = '0; jump_field_sh = '0; jr_target = '0;
        branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0; exc_req = 1'b0;
        stall = 1'b0; imem_ready = 1'b1;

        // Reset and sequential fetch
        #12;
        now("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        now("post_release", 32'h0, 1'b0, 1'b0, 1'b0);
        tick("seq1", 32'd4,  1'b1, 1'b0, 1'b0);
        tick("seq2", 32'd8,  1'b1, 1'b0, 1'b0);
        tick("seq3", 32'd12, 1'b1, 1'b0, 1'b0);
        tick("seq4", 32'd16, 1'b1, 1'b0, 1'b0);

        // Backward branch
        id_pc_plus4 = 32'h0000_0104; branch_offset_sh = 32'hFFFF_FFF0; branch_taken = 1'b1;
        tick("branch", 32'h0000_00F4, 1'b1, 1'b0, 1'b0);
        tick("after_branch", 32'h0000_00F8, 1'b1, 1'b0, 1'b0);

        // Jump field concatenation
        id_pc_plus4 = 32'h4000_0010; jump_field_sh = 28'hABC_DEF0; jump = 1'b1;
        tick("jump", 32'h4ABC_DEF0, 1'b1, 1'b0, 1'b0);

        // Buffered misaligned jr under stall
        stall = 1'b1; jump_reg = 1'b1; jr_target = 32'h0000_2003;
        tick("jr_stall1", 32'h4ABC_DEF0, 1'b0, 1'b1, 1'b1);
        tick("jr_stall2", 32'h4ABC_DEF0, 1'b0, 1'b1, 1'b0);
        tick("jr_stall3", 32'h4ABC_DEF0, 1'b0, 1'b1, 1'b0);
        stall = 1'b0;
        tick("jr_release", 32'h0000_2000, 1'b1, 1'b0, 1'b0);
        tick("after_jr", 32'h0000_2004, 1'b1, 1'b0, 1'b0);

        // Exception beats branch, then survives a later jump
        imem_ready = 1'b0; exc_req = 1'b1; branch_taken = 1'b1;
        tick("exc_wait1", 32'h0000_2004, 1'b0, 1'b1, 1'b0);
        jump = 1'b1;
        tick("exc_wait2", 32'h0000_2004, 1'b0, 1'b1, 1'b0);
        imem_ready = 1'b1;
        tick("exc_release", 32'h8000_0180, 1'b1, 1'b0, 1'b0);

        // Buffered branch replaced by a jump arriving on the advance edge
        imem_ready = 1'b0; branch_taken = 1'b1;
        id_pc_plus4 = 32'h0000_0104; branch_offset_sh = 32'hFFFF_FFF0;
        tick("br_buffered", 32'h8000_0180, 1'b0, 1'b1, 1'b0);
        imem_ready = 1'b1; jump = 1'b1; id_pc_plus4 = 32'h4000_0010;
        tick("jump_overrides", 32'h4ABC_DEF0, 1'b1, 1'b0, 1'b0);

        // Buffered exception kept against a jump arriving on the advance edge
        imem_ready = 1'b0; exc_req = 1'b1;
        tick("exc_buffered", 32'h4ABC_DEF0, 1'b0, 1'b1, 1'b0);
        imem_ready = 1'b1; jump = 1'b1;
        tick("exc_kept", 32'h8000_0180, 1'b1, 1'b0, 1'b0);

        // Exception masks misalignment report from a simultaneous jr
        exc_req = 1'b1; jump_reg = 1'b1; jr_target = 32'h0000_0003;
        tick("exc_jr_mask", 32'h8000_0180, 1'b1, 1'b0, 1'b0);

        // Wrap at top of address space
        jump_reg = 1'b1; jr_target = 32'hFFFF_FFFF;
        tick("wrap_set", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
        tick("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b0);

        // Reset asserted mid-HOLD discards the pending redirect
        tick("pre_hold1", 32'd4, 1'b1, 1'b0, 1'b0);
        tick("pre_hold2", 32'd8, 1'b1, 1'b0, 1'b0);
        stall = 1'b1; jump = 1'b1; id_pc_plus4 = 32'h4000_0010;
        tick("hold_before_reset", 32'd8, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        now("reset_in_hold", 32'h0, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        #1;
        rst_n = 1'b1;
        tick("restart", 32'd4, 1'b1, 1'b0, 1'b0);
        tick("restart2", 32'd8, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
